data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable data memory for the single-cycle datapath's load/store stage.
- Supports byte, halfword and word accesses, little-endian.
- Writes are synchronous on the clock edge; reads are combinational.
- Asynchronous active-low reset clears the entire array.

Parameters:
- DEPTH_BYTES, 256: number of bytes stored; must be a power of two, at least 4.
- ADDR_BITS, log2(DEPTH_BYTES) = 8: number of address LSBs used; derived, not overridden.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_write  input  1  store enable.
- mem_read  input  1  load enable.
- mem_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = invalid.
- address  input  32  byte address.
- write_data  input  32  store data; the low 8/16/32 bits are used according to mem_size.
- read_data  output  32  load data, zero-extended.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Storage is DEPTH_BYTES bytes. Only address[ADDR_BITS-1:0] is used; upper bits are ignored, so addresses wrap modulo DEPTH_BYTES.
- Alignment: the effective address is the address rounded down to natural alignment.
  - Halfword: address bit 0 is cleared.
  - Word: address bits 1:0 are cleared.
- Little-endian: byte at effective address A maps to data[7:0], A+1 to data[15:8], A+2 to data[23:16], A+3 to data[31:24].
- Reset (rst_n = 0): all bytes are cleared to 0 immediately, independent of clk. While reset is held, writes are ignored and read_data = 0.
- Write: on a rising clk edge with rst_n = 1 and mem_write = 1, the 1, 2 or 4 addressed bytes are updated from write_data. All other bytes hold their value.
- mem_size = 11: no write occurs, and a read returns 0.
- Read: combinational.
  - With mem_read = 1, read_data holds the addressed byte/halfword/word, zero-extended to 32 bits.
  - With mem_read = 0, read_data = 0.
- Simultaneous mem_read and mem_write: read_data shows the old contents until the clock edge and the newly written contents after it. Reads never see partially written data.
- Both enables low: memory holds its contents and read_data = 0.
- Reset asserted mid-operation: a pending write is discarded. Contents are 0 once reset releases.

Optional Feature:
- Macro: DATA_MEMORY_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit, combinational).
  - misaligned = 1 when (mem_read or mem_write) is active and the access is misaligned: halfword with address[0] = 1, word with address[1:0] != 00, or mem_size = 11.
  - A misaligned write is suppressed entirely.
  - A misaligned read returns 0.
- Undefined:
  - The misaligned port does not exist.
  - Misaligned accesses are silently aligned down as described under Behaviour.

Test Plan:
- Pulse rst_n low asynchronously between clock edges, then perform a word read at 0x0 -> read_data = 0x00000000 immediately.
- Word write 0xDEADBEEF to 0x0, then word read at 0x0 -> 0xDEADBEEF. Byte reads at 0x0..0x3 -> 0xEF, 0xBE, 0xAD, 0xDE.
- Halfword write 0x0000BEEF to 0x2:
  - halfword read at 0x2 -> 0x0000BEEF
  - word read at 0x0 -> 0xBEEFBEEF
- Byte write 0x000000AA to 0x1:
  - byte read at 0x1 -> 0x000000AA
  - word read at 0x0 -> 0xBEEFAAEF
- Wrap and idle cases:
  - Word write 0x12345678 to 0x104 (wraps to 0x04), then word read at 0x04 -> 0x12345678.
  - mem_read = 0 -> read_data = 0.
  - mem_size = 11 write -> memory unchanged.
- Alignment handling:
  - Macro undefined: word write 0xCAFEF00D to 0x0A, then word read at 0x08 -> 0xCAFEF00D.
  - Macro defined: the same write asserts misaligned = 1 and a word read at 0x08 still returns its prior value.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: synchronous writes, combinational reads.
// Optional DATA_MEMORY_ALIGN_CHECK_EN adds a misaligned flag that blocks misaligned accesses.
module data_memory #(
  parameter int unsigned DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  mem_size,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] read_data
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH_BYTES);

  logic [7:0]           mem [DEPTH_BYTES];
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] a1;
  logic [ADDR_BITS-1:0] a2;
  logic [ADDR_BITS-1:0] a3;
  logic                 size_ok;
  logic                 access_ok;
  logic                 wr_en;

  // Upper address bits are ignored so accesses wrap modulo DEPTH_BYTES.
  logic unused_addr;
  assign unused_addr = ^address[31:ADDR_BITS];

  always_comb begin
    base = address[ADDR_BITS-1:0];
    unique case (mem_size)
      2'b01:   base = {address[ADDR_BITS-1:1], 1'b0};
      2'b10:   base = {address[ADDR_BITS-1:2], 2'b00};
      default: base = address[ADDR_BITS-1:0];
    endcase
  end

  assign a1      = base + ADDR_BITS'(1);
  assign a2      = base + ADDR_BITS'(2);
  assign a3      = base + ADDR_BITS'(3);
  assign size_ok = (mem_size != 2'b11);

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  logic align_err;
  assign align_err = ((mem_size == 2'b01) && address[0]) ||
                     ((mem_size == 2'b10) && (address[1:0] != 2'b00)) ||
                     (mem_size == 2'b11);
  assign misaligned = (mem_read || mem_write) && align_err;
  assign access_ok  = !align_err;
`else
  assign access_ok  = size_ok;
`endif

  assign wr_en = mem_write && access_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[base] <= write_data[7:0];
      if (mem_size != 2'b00) begin
        mem[a1] <= write_data[15:8];
      end
      if (mem_size == 2'b10) begin
        mem[a2] <= write_data[23:16];
        mem[a3] <= write_data[31:24];
      end
    end
  end

  always_comb begin
    read_data = 32'h0000_0000;
    if (rst_n && mem_read && access_ok) begin
      unique case (mem_size)
        2'b00:   read_data = {24'h00_0000, mem[base]};
        2'b01:   read_data = {16'h0000, mem[a1], mem[base]};
        2'b10:   read_data = {mem[a3], mem[a2], mem[a1], mem[base]};
        default: read_data = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized bench for data_memory; expected values flow through a scoreboard queue.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  data_memory #(.DEPTH_BYTES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_size   (mem_size),
    .address    (address),
    .write_data (write_data),
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [7:0]  model [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live read port.
  task automatic sb_check();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, read_data, e);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endfunction

  function automatic void model_write(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d);
    int n;
    int b;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    b = int'(a[7:0]) & ~(n - 1);
    for (int k = 0; k < n; k++) model[(b + k) % 256] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r;
    int n;
    int b;
    r = 32'h0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    b = int'(a[7:0]) & ~(n - 1);
    for (int k = 0; k < n; k++) r[8*k +: 8] = model[(b + k) % 256];
    return r;
  endfunction

  task automatic wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    mem_size   = sz;
    address    = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] e);
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    mem_size  = sz;
    address   = a;
    expect_rd(tag, e);
    #1;
    sb_check();
    mem_read  = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;

    rst_n = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
    mem_size = 2'b10; address = 32'h0; write_data = 32'h0;
    model_clear();

    // Async reset between edges, with a write held through the edge it covers.
    #2 rst_n = 1'b0;
    #1 mem_read = 1'b1; mem_write = 1'b1; write_data = 32'h5555_5555;
    expect_rd("reset_hold_read", 32'h0);
    #1 sb_check();
    #2 mem_write = 1'b0;
    #1 rst_n = 1'b1;
    #1 expect_rd("reset_release_read", 32'h0);
    sb_check();
    mem_read = 1'b0;

    wr(2'b10, 32'h0, 32'hDEAD_BEEF); model_write(2'b10, 32'h0, 32'hDEAD_BEEF);
    rd("word_0", 2'b10, 32'h0, 32'hDEAD_BEEF);
    rd("byte_0", 2'b00, 32'h0, 32'h0000_00EF);
    rd("byte_1", 2'b00, 32'h1, 32'h0000_00BE);
    rd("byte_2", 2'b00, 32'h2, 32'h0000_00AD);
    rd("byte_3", 2'b00, 32'h3, 32'h0000_00DE);

    wr(2'b01, 32'h2, 32'h0000_BEEF); model_write(2'b01, 32'h2, 32'h0000_BEEF);
    rd("half_2", 2'b01, 32'h2, 32'h0000_BEEF);
    rd("word_after_half", 2'b10, 32'h0, 32'hBEEF_BEEF);

    wr(2'b00, 32'h1, 32'h0000_00AA); model_write(2'b00, 32'h1, 32'h0000_00AA);
    rd("byte_1_after", 2'b00, 32'h1, 32'h0000_00AA);
    rd("word_after_byte", 2'b10, 32'h0, 32'hBEEF_AAEF);

    wr(2'b10, 32'h104, 32'h1234_5678); model_write(2'b10, 32'h104, 32'h1234_5678);
    rd("wrap_word_4", 2'b10, 32'h04, 32'h1234_5678);
    rd("wrap_alias_204", 2'b10, 32'hFFFF_FF04, 32'h1234_5678);

    @(negedge clk);
    mem_read = 1'b0; mem_size = 2'b10; address = 32'h0;
    expect_rd("read_disabled", 32'h0);
    #1 sb_check();

    wr(2'b11, 32'h0, 32'hFFFF_FFFF);
    rd("size11_no_write", 2'b10, 32'h0, 32'hBEEF_AAEF);
    rd("size11_read_zero", 2'b11, 32'h0, 32'h0);

    wr(2'b00, 32'hFF, 32'h0000_005A); model_write(2'b00, 32'hFF, 32'h0000_005A);
    rd("top_byte", 2'b00, 32'hFF, 32'h0000_005A);
    rd("top_word", 2'b10, 32'hFC, 32'h5A00_0000);

    // Read-during-write: old data before the edge, new data after.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; mem_size = 2'b10;
    address = 32'h10; write_data = 32'h1122_3344;
    expect_rd("rdw_before_edge", 32'h0);
    expect_rd("rdw_after_edge", 32'h1122_3344);
    #1 sb_check();
    @(posedge clk);
    #1 sb_check();
    mem_write = 1'b0; mem_read = 1'b0;
    model_write(2'b10, 32'h10, 32'h1122_3344);

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    @(negedge clk);
    mem_write = 1'b1; mem_size = 2'b10; address = 32'h0A; write_data = 32'hCAFE_F00D;
    #1 chk("misaligned_flag_word", {31'h0, misaligned}, 32'h1);
    @(posedge clk);
    #1 mem_write = 1'b0;
    rd("misaligned_write_dropped", 2'b10, 32'h08, 32'h0);
    rd("misaligned_half_read_zero", 2'b01, 32'h3, 32'h0);
    @(negedge clk);
    mem_read = 1'b1; mem_size = 2'b10; address = 32'h08;
    #1 chk("aligned_flag_clear", {31'h0, misaligned}, 32'h0);
    mem_read = 1'b0;
`else
    wr(2'b10, 32'h0A, 32'hCAFE_F00D); model_write(2'b10, 32'h0A, 32'hCAFE_F00D);
    rd("align_down_word", 2'b10, 32'h08, 32'hCAFE_F00D);
    rd("align_down_half", 2'b01, 32'h3, 32'h0000_BEEF);
`endif

    // Randomized naturally aligned traffic against the byte model.
    for (int it = 0; it < 24; it++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      a[1:0] = (sz == 2'b10) ? 2'b00 : (sz == 2'b01) ? {a[1], 1'b0} : a[1:0];
      d  = $urandom;
      wr(sz, a, d);
      model_write(sz, a, d);
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      a[1:0] = (sz == 2'b10) ? 2'b00 : (sz == 2'b01) ? {a[1], 1'b0} : a[1:0];
      rd("rand_read", sz, a, model_read(sz, a));
    end

    // Reset asserted while a write is pending discards it and clears everything.
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b1; mem_size = 2'b10;
    address = 32'h20; write_data = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    expect_rd("reset_mid_read", 32'h0);
    #1 sb_check();
    @(posedge clk);
    #1 mem_write = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    rd("after_reset_pending", 2'b10, 32'h20, 32'h0);
    rd("after_reset_word_0", 2'b10, 32'h0, 32'h0);
    rd("after_reset_word_4", 2'b10, 32'h4, 32'h0);
    rd("after_reset_top", 2'b10, 32'hFC, 32'h0);

    if (exp_q.size() != 0) chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
